// File: rtl/vector_issue_sequencer_pkg.sv
// Shared types and encodings for the vector issue sequencer.
package vector_issue_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOAD = 2'd2
    } vseq_state_e;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    localparam logic [2:0] LMUL_1 = 3'd0;
    localparam logic [2:0] LMUL_2 = 3'd1;
    localparam logic [2:0] LMUL_4 = 3'd2;
    localparam logic [2:0] LMUL_8 = 3'd3;

    localparam int DEF_LANES_DATA_WIDTH = 64;
    localparam int DEF_MICROOP_BIT      = 9;
    localparam int DEF_VL_BITS          = 7;

    // Reserved sew/lmul codes (4..7) fold to code 0.
    function automatic logic [1:0] legal_code(input logic [2:0] code);
        return code[2] ? 2'd0 : code[1:0];
    endfunction

endpackage

// File: rtl/vector_issue_sequencer_if.sv
// Decoder-side instruction handshake plus lane-side uop bus.
interface vector_issue_sequencer_if
    import vector_issue_sequencer_pkg::*;
#(
    parameter int LANES_DATA_WIDTH = DEF_LANES_DATA_WIDTH,
    parameter int MICROOP_BIT      = DEF_MICROOP_BIT,
    parameter int VL_BITS          = DEF_VL_BITS
) ();

    logic                          instr_valid;
    logic                          instr_ready;
    logic [MICROOP_BIT-1:0]        instr_alu_op;
    logic [4:0]                    instr_src1;
    logic [4:0]                    instr_src2;
    logic [4:0]                    instr_dest;
    logic [2:0]                    instr_lmul;
    logic [2:0]                    instr_sew;
    logic [VL_BITS-1:0]            instr_vl;
    logic                          instr_load;
    logic                          instr_store;
    logic                          instr_indexed;
    logic                          instr_masked;
    logic                          instr_wb_en;

    logic                          lane_stall;
    logic                          load_done;

    logic                          uop_valid;
    logic [MICROOP_BIT-1:0]        uop_alu_op;
    logic [4:0]                    uop_src1;
    logic [4:0]                    uop_src2;
    logic [4:0]                    uop_dest;
    logic [LANES_DATA_WIDTH/8-1:0] uop_mask_bits;
    logic [2:0]                    uop_sew;
    logic                          uop_load;
    logic                          uop_store;
    logic                          uop_indexed;
    logic                          uop_masked;
    logic                          uop_wb_en;

    logic                          busy;
    logic                          illegal_cfg;

    modport master (
        output instr_valid, instr_alu_op, instr_src1, instr_src2, instr_dest,
               instr_lmul, instr_sew, instr_vl, instr_load, instr_store,
               instr_indexed, instr_masked, instr_wb_en, lane_stall, load_done,
        input  instr_ready, uop_valid, uop_alu_op, uop_src1, uop_src2, uop_dest,
               uop_mask_bits, uop_sew, uop_load, uop_store, uop_indexed,
               uop_masked, uop_wb_en, busy, illegal_cfg
    );

    modport slave (
        input  instr_valid, instr_alu_op, instr_src1, instr_src2, instr_dest,
               instr_lmul, instr_sew, instr_vl, instr_load, instr_store,
               instr_indexed, instr_masked, instr_wb_en, lane_stall, load_done,
        output instr_ready, uop_valid, uop_alu_op, uop_src1, uop_src2, uop_dest,
               uop_mask_bits, uop_sew, uop_load, uop_store, uop_indexed,
               uop_masked, uop_wb_en, busy, illegal_cfg
    );

endinterface

// File: rtl/vector_issue_sequencer_tail_mask.sv
// Tail byte-enables for one uop: the low min(rem << sew, bytes-per-reg)
// bits are set, where rem = vl_eff - idx*EPR.
module vector_issue_sequencer_tail_mask #(
    parameter int LANES_DATA_WIDTH = 64,
    parameter int VL_BITS          = 7
) (
    input  logic [VL_BITS-1:0]            vl_eff,
    input  logic [2:0]                    idx,
    input  logic [1:0]                    sew,
    output logic [LANES_DATA_WIDTH/8-1:0] mask_bits
);

    localparam int BYTES   = LANES_DATA_WIDTH / 8;
    localparam int EPR_LOG = $clog2(BYTES);
    localparam int W       = VL_BITS + 4;

    logic [4:0]   epr_log;
    logic [W-1:0] offset;
    logic [W-1:0] rem;
    logic [W-1:0] scaled;

    // Thermometer decode of the live byte count; saturates at a full register.
    always_comb begin
        epr_log = 5'(EPR_LOG) - {3'b000, sew};
        offset  = W'(idx) << epr_log;
        rem     = W'(vl_eff) - offset;
        scaled  = rem << sew;
        for (int b = 0; b < BYTES; b++) begin
            mask_bits[b] = (W'(b) < scaled);
        end
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Splits a decoded vector instruction into one uop per register of its
// group, with tail byte-enables, holding on lane stalls and pausing after
// each load uop until the lane reports the load written back.
module vector_issue_sequencer
    import vector_issue_sequencer_pkg::*;
#(
    parameter int LANES_DATA_WIDTH = DEF_LANES_DATA_WIDTH,
    parameter int MICROOP_BIT      = DEF_MICROOP_BIT,
    parameter int VL_BITS          = DEF_VL_BITS
) (
    input logic                    clk,
    input logic                    rst,
    vector_issue_sequencer_if.slave bus
);

    localparam int BYTES   = LANES_DATA_WIDTH / 8;
    localparam int EPR_LOG = $clog2(BYTES);
    localparam int VW      = VL_BITS + 1;

    vseq_state_e state, state_next;

    logic [MICROOP_BIT-1:0] alu_q;
    logic [4:0]             src1_q, src2_q, dest_q;
    logic [1:0]             sew_q;
    logic [VL_BITS-1:0]     vl_eff_q;
    logic [2:0]             last_q;
    logic                   load_q, store_q, indexed_q, masked_q, wb_q;
    logic [2:0]             idx;
    logic                   more_q;
    logic                   illegal_q;

    logic                   accept;
    logic                   handled;
    logic                   ready;
    logic                   valid;
    logic                   busy;

    logic [1:0]             sew_in, lmul_in;
    logic [4:0]             epr_log_in;
    logic [VW-1:0]          vlmax_in;
    logic [VL_BITS-1:0]     vl_eff_in;
    logic [VL_BITS-1:0]     vl_m1_in;
    logic [2:0]             last_in;
    logic [BYTES-1:0]       mask_raw;

    assign accept  = bus.instr_valid && ready;
    assign handled = (state == ISSUE) && !bus.lane_stall;

    // Group geometry of the offered instruction, with reserved codes folded to 0.
    always_comb begin
        sew_in     = legal_code(bus.instr_sew);
        lmul_in    = legal_code(bus.instr_lmul);
        epr_log_in = 5'(EPR_LOG) - {3'b000, sew_in};
        vlmax_in   = VW'(1) << (epr_log_in + {3'b000, lmul_in});
        vl_eff_in  = ({1'b0, bus.instr_vl} > vlmax_in) ? VL_BITS'(vlmax_in) : bus.instr_vl;
        vl_m1_in   = vl_eff_in - VL_BITS'(1);
        last_in    = 3'(vl_m1_in >> epr_log_in);
    end

    // Instruction latch, loaded on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            dest_q    <= '0;
            sew_q     <= '0;
            vl_eff_q  <= '0;
            last_q    <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            indexed_q <= 1'b0;
            masked_q  <= 1'b0;
            wb_q      <= 1'b0;
        end else if (accept) begin
            alu_q     <= bus.instr_alu_op;
            src1_q    <= bus.instr_src1;
            src2_q    <= bus.instr_src2;
            dest_q    <= bus.instr_dest;
            sew_q     <= sew_in;
            vl_eff_q  <= vl_eff_in;
            last_q    <= last_in;
            load_q    <= bus.instr_load;
            store_q   <= bus.instr_store;
            indexed_q <= bus.instr_indexed;
            masked_q  <= bus.instr_masked;
            wb_q      <= bus.instr_wb_en;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (accept && (bus.instr_vl != '0)) state_next = ISSUE;
            end
            ISSUE: begin
                valid = 1'b1;
                if (!bus.lane_stall) begin
                    if (load_q)              state_next = WAIT_LOAD;
                    else if (idx == last_q)  state_next = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (bus.load_done) state_next = more_q ? ISSUE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Group index; also remembers whether uops remain across a load wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            more_q <= 1'b0;
        end else if (accept) begin
            idx    <= '0;
            more_q <= 1'b0;
        end else if (handled) begin
            more_q <= (idx != last_q);
            if (idx != last_q) idx <= idx + 3'd1;
        end
    end

    // One-cycle pulse flagging a reserved sew/lmul on the accepted instruction.
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= accept && (bus.instr_lmul[2] || bus.instr_sew[2]);
    end

    vector_issue_sequencer_tail_mask #(
        .LANES_DATA_WIDTH (LANES_DATA_WIDTH),
        .VL_BITS          (VL_BITS)
    ) u_tail_mask (
        .vl_eff    (vl_eff_q),
        .idx       (idx),
        .sew       (sew_q),
        .mask_bits (mask_raw)
    );

    assign bus.instr_ready   = ready;
    assign bus.busy          = busy;
    assign bus.illegal_cfg   = illegal_q;
    assign bus.uop_valid     = valid;
    assign bus.uop_alu_op    = valid ? alu_q : '0;
    assign bus.uop_src1      = valid ? src1_q + 5'(idx) : '0;
    assign bus.uop_src2      = valid ? src2_q + 5'(idx) : '0;
    assign bus.uop_dest      = valid ? dest_q + 5'(idx) : '0;
    assign bus.uop_mask_bits = valid ? mask_raw : '0;
    assign bus.uop_sew       = valid ? {1'b0, sew_q} : '0;
    assign bus.uop_load      = valid && load_q;
    assign bus.uop_store     = valid && store_q;
    assign bus.uop_indexed   = valid && indexed_q;
    assign bus.uop_masked    = valid && masked_q;
    assign bus.uop_wb_en     = valid && wb_q;

endmodule
